// File: rtl/stage_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and its memory.
interface stage_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch stage: single-outstanding imem requester, small instruction
// buffer, and a decode-facing output register with stall/nullify/redirect control.
module stage_fetch #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          nullify,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  stage_fetch_if.master imem,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pcadd4,
  output logic [31:0]   out_instruction
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {F_REQ, F_WAIT, F_DROP} fetch_state_e;

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] fetch_pc_q;

  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fifo_count_q;

  logic req;
  logic handshake;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_not_full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_not_full = (fifo_count_q < FullCnt);
  assign handshake     = req & imem.imem_ready;
  // A redirect flushes the buffer, so nothing may leave it in that cycle.
  assign fifo_pop      = !redirect_valid && !nullify && !stall && (fifo_count_q != '0);

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= F_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a redirect while a request is in flight routes through F_DROP
  // so the stale response is swallowed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      F_REQ: begin
        if (handshake) begin
          state_d = redirect_valid ? F_DROP : F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = F_REQ;
        end else if (redirect_valid) begin
          state_d = F_DROP;
        end
      end
      F_DROP: begin
        if (imem.imem_rvalid) begin
          state_d = F_REQ;
        end
      end
      default: state_d = F_REQ;
    endcase
  end

  // FSM outputs: issue only when the buffer can absorb the response.
  always_comb begin
    req       = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      F_REQ:   req = fifo_not_full;
      F_WAIT:  fifo_push = imem.imem_rvalid && !redirect_valid;
      default: ;
    endcase
  end

  // Fetch PC and the address of the in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
    end else begin
      if (handshake) begin
        fetch_pc_q <= pc_q;
      end
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (handshake) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  // Instruction buffer; simultaneous push and pop both take effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (fifo_push) begin
        fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
        fifo_instr_q[wr_ptr_q] <= imem.imem_rdata;
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (fifo_push && !fifo_pop) begin
        fifo_count_q <= fifo_count_q + CntW'(1);
      end else if (!fifo_push && fifo_pop) begin
        fifo_count_q <= fifo_count_q - CntW'(1);
      end
    end
  end

  // Decode-facing output register; an invalid slot always carries a nop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_pcadd4      <= '0;
      out_instruction <= '0;
    end else if (redirect_valid || nullify) begin
      out_valid       <= 1'b0;
      out_instruction <= '0;
    end else if (!stall) begin
      if (fifo_pop) begin
        out_valid       <= 1'b1;
        out_pc          <= fifo_pc_q[rd_ptr_q];
        out_pcadd4      <= fifo_pc_q[rd_ptr_q] + 32'd4;
        out_instruction <= fifo_instr_q[rd_ptr_q];
      end else begin
        out_valid       <= 1'b0;
        out_instruction <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch with a simple variable-latency memory model.
module tb_stage_fetch;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        nullify;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pcadd4;
  logic [31:0] out_instruction;

  stage_fetch_if imem ();

  stage_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .nullify         (nullify),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem            (imem.master),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_pcadd4      (out_pcadd4),
    .out_instruction (out_instruction)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Memory model: one pending response.
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic        pend_drop;
  int unsigned pend_lat;
  int unsigned mem_lat;

  // Expected fetch address and output register.
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic [31:0] exp_opc;
  logic [31:0] exp_opc4;
  logic [31:0] exp_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    pend_valid = 1'b0;
    pend_addr  = '0;
    pend_drop  = 1'b0;
    pend_lat   = 0;
    exp_pc     = RESET_PC;
    exp_valid  = 1'b0;
    exp_opc    = '0;
    exp_opc4   = '0;
    exp_instr  = '0;
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases at a negedge.
  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    nullify = 1'b0;
    redirect_valid = 1'b0;
    imem.imem_ready = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_pcadd4", out_pcadd4, 32'd0);
    check("rst_out_instr", out_instruction, 32'd0);
    check("rst_imem_req", 32'(imem.imem_req), 32'd1);
    check("rst_imem_addr", imem.imem_addr, RESET_PC);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cycle(input logic st, input logic nul, input logic redir,
                       input logic [31:0] rpc, input logic rdy);
    logic   rv;
    logic   exp_req;
    logic   hs;
    logic   deliver;
    entry_t e;
    entry_t h;
    stall = st;
    nullify = nul;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem.imem_ready = rdy;
    rv = pend_valid && (pend_lat == 0);
    imem.imem_rvalid = rv;
    imem.imem_rdata = rv ? (pend_drop ? 32'hDEAD_BEEF : (pend_addr ^ 32'h0000_FFFF)) : 32'h0;
    #1;
    exp_req = !pend_valid && (sb_q.size() < 2);
    check("imem_req", 32'(imem.imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem.imem_addr, exp_pc);
    hs = exp_req && rdy;

    deliver = rv && !pend_drop && !redir;
    e.pc = pend_addr;
    e.instr = pend_addr ^ 32'h0000_FFFF;
    if (rv) begin
      pend_valid = 1'b0;
    end else if (pend_valid) begin
      if (redir) pend_drop = 1'b1;
      if (pend_lat > 0) pend_lat--;
    end
    if (hs) begin
      pend_valid = 1'b1;
      pend_addr = exp_pc;
      pend_drop = redir;
      pend_lat = mem_lat - 1;
    end
    if (redir) exp_pc = rpc;
    else if (hs) exp_pc = exp_pc + 32'd4;

    if (redir) begin
      exp_valid = 1'b0;
      exp_instr = '0;
      sb_q.delete();
    end else if (nul) begin
      exp_valid = 1'b0;
      exp_instr = '0;
    end else if (!st) begin
      if (sb_q.size() > 0) begin
        h = sb_q.pop_front();
        exp_valid = 1'b1;
        exp_opc = h.pc;
        exp_opc4 = h.pc + 32'd4;
        exp_instr = h.instr;
      end else begin
        exp_valid = 1'b0;
        exp_instr = '0;
      end
    end
    if (deliver) sb_q.push_back(e);

    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("out_instruction", out_instruction, exp_instr);
    if (exp_valid) begin
      check("out_pc", out_pc, exp_opc);
      check("out_pcadd4", out_pcadd4, exp_opc4);
    end
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    nullify = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem.imem_ready = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    mem_lat = 1;
    model_reset();
    #1;
    do_reset();

    // Streaming fetch from RESET_PC.
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Long stall: buffer fills, requests stop, then drain in order.
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while waiting on a response.
    mem_lat = 2;
    for (int k = 0; k < 12 && !(pend_valid && pend_lat > 0 && !pend_drop); k++)
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    if (!(pend_valid && pend_lat > 0)) check("reach_f_wait", 32'd0, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 32'h0040_0000, 1'b1);
    mem_lat = 1;
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Nullify under stall with a valid output and buffered words.
    for (int k = 0; k < 12 && !exp_valid; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    if (!exp_valid) check("reach_out_valid", 32'd0, 32'd1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while a request is outstanding and the buffer holds data.
    mem_lat = 3;
    for (int k = 0; k < 20 && !(pend_valid && sb_q.size() > 0); k++)
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    if (!(pend_valid && sb_q.size() > 0)) check("reach_wait_full", 32'd0, 32'd1);
    do_reset();
    mem_lat = 1;

    // Redirect in the same cycle as the handshake for RESET_PC+8.
    for (int k = 0; k < 12 && !(!pend_valid && sb_q.size() < 2 && exp_pc == 32'hBFC0_0008); k++)
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    if (exp_pc != 32'hBFC0_0008) check("reach_pc8", exp_pc, 32'hBFC0_0008);
    cycle(1'b0, 1'b0, 1'b1, 32'h0040_0000, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random mix of stalls, nullifies, redirects, ready and latency.
    for (int k = 0; k < 400; k++) begin
      mem_lat = 1 + ($urandom % 3);
      cycle(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 16) == 0,
            $urandom & 32'hFFFF_FFFC, ($urandom % 4) != 0);
    end
    mem_lat = 1;
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
